encoder_poller: RTL and testbench

ENCODER_POLLER -- requirements
Module: encoder_poller

---
 rtl/encoder_poller.sv | 149 ++++++++++++++
 tb/tb_encoder_poller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/encoder_poller.sv
// rtl/encoder_poller.sv - polls N_ENC rotary encoders each round and streams clamped channel value updates
module encoder_poller #(
   parameter int N_ENC       = 4,
   parameter int POLL_CYCLES = 100000,
   parameter int TIMEOUT     = 16,
   parameter int VMIN        = 0,
   parameter int VMAX        = 1023
) (
   input  logic                 aclk,
   input  logic                 reset,
   input  logic [N_ENC-1:0]     enc_valid,
   input  logic [8*N_ENC-1:0]   enc_delta,
   output logic [N_ENC-1:0]     enc_read,
   output logic                 upd_valid,
   input  logic                 upd_ready,
   output logic [2:0]           upd_chan,
   output logic [15:0]          upd_value,
   output logic                 err,
   output logic                 busy
);

   localparam int PCW = $clog2(POLL_CYCLES);
   localparam int TW  = $clog2(TIMEOUT + 1);
   localparam logic [PCW-1:0]    POLL_LAST = PCW'(POLL_CYCLES - 1);
   localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [2:0]        CH_LAST   = 3'(N_ENC - 1);
   localparam logic [N_ENC-1:0]  READ0     = N_ENC'(1);
   localparam logic signed [16:0] LO = 17'(VMIN);
   localparam logic signed [16:0] HI = 17'(VMAX);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_RELEASE, S_UPDATE, S_NEXT} state_t;

   state_t             state;
   logic [PCW-1:0]     poll_cnt;
   logic [TW-1:0]      timer;
   logic [2:0]         ch;
   logic [7:0]         delta_q;
   logic [15:0]        value [N_ENC];

   logic               sel_valid;
   logic [7:0]         sel_delta;
   logic [15:0]        cur_value;
   logic signed [16:0] sum;
   logic [15:0]        new_value;

   // Mux the current channel's encoder and value, then clamp at 17 bits so no add can wrap.
   always_comb begin
      sel_valid = 1'b0;
      sel_delta = '0;
      cur_value = '0;
      for (int i = 0; i < N_ENC; i++) begin
         if (ch == 3'(i)) begin
            sel_valid = enc_valid[i];
            sel_delta = enc_delta[8*i +: 8];
            cur_value = value[i];
         end
      end
      sum = {cur_value[15], cur_value} + {{9{delta_q[7]}}, delta_q};
      if (sum < LO)
         new_value = LO[15:0];
      else if (sum > HI)
         new_value = HI[15:0];
      else
         new_value = sum[15:0];
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         poll_cnt  <= '0;
         timer     <= '0;
         ch        <= '0;
         delta_q   <= '0;
         for (int i = 0; i < N_ENC; i++) value[i] <= '0;
         enc_read  <= '0;
         upd_valid <= 1'b0;
         upd_chan  <= '0;
         upd_value <= '0;
         err       <= 1'b0;
      end else begin
         err      <= 1'b0;
         // Free-running: a round start that lands while busy is simply lost.
         poll_cnt <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + PCW'(1);
         case (state)
            S_IDLE: begin
               if (poll_cnt == POLL_LAST) begin
                  ch       <= '0;
                  timer    <= '0;
                  enc_read <= READ0;
                  state    <= S_REQ;
               end
            end
            S_REQ: begin
               if (sel_valid) begin
                  delta_q  <= sel_delta;
                  enc_read <= '0;
                  timer    <= '0;
                  state    <= S_RELEASE;
               end else if (timer == TMO_LAST) begin
                  err      <= 1'b1;
                  enc_read <= '0;
                  state    <= S_NEXT;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            S_RELEASE: begin
               if (!sel_valid) begin
                  if (delta_q != '0) begin
                     upd_valid <= 1'b1;
                     upd_chan  <= ch;
                     upd_value <= new_value;
                     for (int i = 0; i < N_ENC; i++)
                        if (ch == 3'(i)) value[i] <= new_value;
                     state <= S_UPDATE;
                  end else begin
                     state <= S_NEXT;
                  end
               end else if (timer == TMO_LAST) begin
                  err   <= 1'b1;
                  state <= S_NEXT;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            S_UPDATE: begin
               if (upd_ready) begin
                  upd_valid <= 1'b0;
                  state     <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (ch == CH_LAST) begin
                  state <= S_IDLE;
               end else begin
                  ch       <= ch + 3'd1;
                  timer    <= '0;
                  enc_read <= READ0 << (ch + 3'd1);
                  state    <= S_REQ;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_encoder_poller.sv
// tb/tb_encoder_poller.sv - scoreboard bench for encoder_poller with handshaking encoder models
module tb_encoder_poller;
   localparam int N  = 4;
   localparam int PC = 50;
   localparam int TO = 16;

   logic             aclk = 1'b0;
   logic             reset = 1'b1;
   logic [N-1:0]     enc_valid = '0;
   logic [8*N-1:0]   enc_delta;
   logic [N-1:0]     enc_read;
   logic             upd_valid;
   logic             upd_ready = 1'b1;
   logic [2:0]       upd_chan;
   logic [15:0]      upd_value;
   logic             err;
   logic             busy;

   int               n_vec = 0;
   int               n_bad = 0;
   logic [7:0]       dl [N];
   logic [N-1:0]     dead = '0;
   logic [N-1:0]     read_q = '0;
   logic [N-1:0]     prev_read = '0;
   int               model_val [N];
   int               exp_chan [$];
   int               exp_val [$];
   logic [N-1:0]     order [$];
   int               rd2_cnt = 0;
   int               err_cnt = 0;
   int               n_edges;

   always #5 aclk = ~aclk;

   encoder_poller #(
      .N_ENC(N), .POLL_CYCLES(PC), .TIMEOUT(TO), .VMIN(0), .VMAX(1023)
   ) dut (
      .aclk(aclk), .reset(reset), .enc_valid(enc_valid), .enc_delta(enc_delta),
      .enc_read(enc_read), .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_chan(upd_chan), .upd_value(upd_value), .err(err), .busy(busy)
   );

   always_comb
      for (int i = 0; i < N; i++) enc_delta[8*i +: 8] = dl[i];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int clampv(input int v);
      return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
   endfunction

   // Encoder models answer one cycle after read and release one cycle after read drops.
   always @(negedge aclk) begin
      enc_valid = read_q & ~dead;
      read_q    = enc_read;
      chk("read_onehot0", 32'($onehot0(enc_read)), 1);
      if (!busy || upd_valid) chk("read_idle_upd", enc_read, 0);
      if (enc_read[2]) rd2_cnt++;
      if (err) err_cnt++;
      if (enc_read != '0 && prev_read == '0) order.push_back(enc_read);
      prev_read = enc_read;
      if (upd_valid && upd_ready) begin
         if (exp_chan.size() == 0) begin
            chk("unexpected_upd", 1, 0);
         end else begin
            chk("upd_chan", upd_chan, exp_chan.pop_front());
            chk("upd_value", upd_value, exp_val.pop_front());
         end
      end
   end

   task automatic launch(input int d0, input int d1, input int d2, input int d3, input logic [N-1:0] dd);
      int d [N];
      d = '{d0, d1, d2, d3};
      dead = dd;
      order.delete();
      rd2_cnt = 0;
      err_cnt = 0;
      for (int i = 0; i < N; i++) begin
         dl[i] = 8'(d[i]);
         if (d[i] != 0 && !dd[i]) begin
            model_val[i] = clampv(model_val[i] + d[i]);
            exp_chan.push_back(i);
            exp_val.push_back(model_val[i]);
         end
      end
   endtask

   task automatic count_to_busy(output int n);
      n = 0;
      while (n < 200) begin
         @(posedge aclk); #1;
         n++;
         if (busy) return;
      end
      chk("tmo_busy", 0, 1);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 600; k++) begin
         @(posedge aclk); #1;
         if (!busy) begin
            chk("sb_empty", exp_chan.size(), 0);
            return;
         end
      end
      chk("tmo_idle", 0, 1);
   endtask

   task automatic round(input int d0, input int d1, input int d2, input int d3, input logic [N-1:0] dd);
      launch(d0, d1, d2, d3, dd);
      count_to_busy(n_edges);
      wait_idle();
   endtask

   initial begin
      bit seen;
      for (int i = 0; i < N; i++) begin
         dl[i] = '0;
         model_val[i] = 0;
      end
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_read", enc_read, 0);
      chk("rst_upd_valid", upd_valid, 0);
      chk("rst_upd_chan", upd_chan, 0);
      chk("rst_upd_value", upd_value, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);

      // Deltas 0,+3,0,-2: two updates, channel 3 clamped at the lower bound.
      launch(0, 3, 0, -2, '0);
      reset = 1'b0;
      count_to_busy(n_edges);
      chk("first_round_start", n_edges, PC);
      wait_idle();
      chk("no_err_round1", err_cnt, 0);

      // Walk channel 0 up to 1020, then clamp at 1023 and step back down.
      for (int r = 0; r < 8; r++) round(127, 0, 0, 0, '0);
      round(4, 0, 0, 0, '0);
      round(7, 0, 0, 0, '0);
      round(-5, 0, 0, 0, '0);

      // Consumer stall during UPDATE.
      upd_ready = 1'b0;
      launch(0, 5, 0, 0, '0);
      count_to_busy(n_edges);
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(posedge aclk); #1;
         seen = upd_valid;
      end
      chk("stall_seen", seen, 1);
      repeat (20) begin
         @(negedge aclk);
         chk("stall_valid", upd_valid, 1);
         chk("stall_chan", upd_chan, 1);
         chk("stall_value", upd_value, 8);
         chk("stall_read", enc_read, 0);
      end
      chk("stall_polled", order.size(), 2);
      @(posedge aclk); #1;
      upd_ready = 1'b1;
      wait_idle();

      // Channel 2 never answers: one err pulse, 16 cycles of read, channel 3 still served.
      round(0, 0, 0, 4, 4'b0100);
      chk("tmo_err_cnt", err_cnt, 1);
      chk("tmo_read2_cycles", rd2_cnt, TO);
      chk("tmo_order_len", order.size(), N);
      for (int i = 0; i < N && i < order.size(); i++)
         chk("tmo_order", order[i], 32'(1) << i);

      // Reset while channel 1 is being read.
      launch(9, 9, 9, 9, '0);
      count_to_busy(n_edges);
      seen = enc_read[1];
      for (int k = 0; k < 100 && !seen; k++) begin
         @(posedge aclk); #1;
         seen = enc_read[1];
      end
      chk("rst_mid_seen", seen, 1);
      #1;
      reset = 1'b1;
      #1;
      chk("rst_mid_read", enc_read, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_upd_valid", upd_valid, 0);
      exp_chan.delete();
      exp_val.delete();
      for (int i = 0; i < N; i++) model_val[i] = 0;
      repeat (2) @(posedge aclk);
      #1;
      launch(1, 0, 0, -1, '0);
      reset = 1'b0;
      count_to_busy(n_edges);
      chk("rst_round_start", n_edges, PC);
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
